// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, ALU and mux select values, and the per-cycle control word.
package mips_pkg;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctl_e;

    // ALUOP_NONE parks alu_ctl at 000 in states that do not use the ALU.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } aluop_e;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_w;
        logic       iord;
        logic       ir_w;
        logic       pc_w;
        logic       pc_w_cond;
        logic [1:0] pc_src;
        logic       reg_w;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        aluop_e     aluop;
        logic       illegal;
        logic       retire;
    } ctrl_t;

    function automatic logic is_legal_funct(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control-unit bundle: instruction fields and status in, datapath/memory
// strobes out. The control unit is the master.
interface mips_mc_control_if;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_w;
    logic        iord;
    logic        ir_w;
    logic        pc_w;
    logic        pc_w_cond;
    logic [1:0]  pc_src;
    logic        reg_w;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_ctl;
    logic        illegal;
    logic [31:0] retired;
    logic [3:0]  state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_w, iord, ir_w, pc_w, pc_w_cond, pc_src, reg_w,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctl, illegal,
               retired, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_w, iord, ir_w, pc_w, pc_w_cond, pc_src, reg_w,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctl, illegal,
               retired, state
    );

endinterface

// File: rtl/mips_mc_control_alu_dec.sv
// ALU decoder: turns the FSM's coarse aluop plus the R-type funct field
// into the 3-bit ALU control code.
module mips_alu_dec
    import mips_pkg::*;
(
    input  aluop_e      aluop,
    input  logic [5:0]  funct,
    output alu_ctl_e    alu_ctl
);

    always_comb begin
        // NOTE: every path assigns alu_ctl (default arms included) so no latch is inferred.
        unique case (aluop)
            ALUOP_ADD: alu_ctl = ALU_ADD;
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                unique case (funct)
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
            default: alu_ctl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS32 control FSM: sequences fetch/decode/execute/memory/
// writeback, handshakes with memory via mem_ready, and counts retirements.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    mips_mc_control_if.master  bus
);

    state_e      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    ctrl_t       ctrl;
    alu_ctl_e    alu_ctl;

    logic decode_legal;
    assign decode_legal = (bus.opcode == OP_LW)   || (bus.opcode == OP_SW)  ||
                          (bus.opcode == OP_ADDI) || (bus.opcode == OP_BEQ) ||
                          (bus.opcode == OP_J)    ||
                          ((bus.opcode == OP_RTYPE) && is_legal_funct(bus.funct));

    // NOTE: synchronous reset; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RST;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!decode_legal)                                      state_d = S_FETCH;
                else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) state_d = S_MEMADR;
                else if (bus.opcode == OP_RTYPE)                         state_d = S_EXEC;
                else if (bus.opcode == OP_ADDI)                          state_d = S_ADDIEX;
                else if (bus.opcode == OP_BEQ)                           state_d = S_BRANCH;
                else                                                     state_d = S_JUMP;
            end
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_RST;
        endcase
    end

    always_comb begin
        ctrl       = '0;
        ctrl.aluop = ALUOP_NONE;
        unique case (state_q)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.aluop     = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_w      = bus.mem_ready;
                ctrl.pc_w      = bus.mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.aluop     = ALUOP_ADD;
                ctrl.illegal   = !decode_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.aluop     = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_w      = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_w   = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.retire  = bus.mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_w   = 1'b1;
                ctrl.reg_dst = 1'b1;
                ctrl.retire  = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_w  = 1'b1;
                ctrl.retire = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.aluop     = ALUOP_SUB;
                ctrl.pc_w_cond = 1'b1;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.retire    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_w   = 1'b1;
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.retire = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter wraps naturally at 32 bits.
    assign retired_d = retired_q + {31'd0, ctrl.retire};

    mips_alu_dec u_alu_dec (
        .aluop   (ctrl.aluop),
        .funct   (bus.funct),
        .alu_ctl (alu_ctl)
    );

    assign bus.mem_req    = ctrl.mem_req;
    assign bus.mem_w      = ctrl.mem_w;
    assign bus.iord       = ctrl.iord;
    assign bus.ir_w       = ctrl.ir_w;
    assign bus.pc_w       = ctrl.pc_w;
    assign bus.pc_w_cond  = ctrl.pc_w_cond;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.reg_w      = ctrl.reg_w;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_ctl    = alu_ctl;
    assign bus.illegal    = ctrl.illegal;
    assign bus.retired    = retired_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: a per-instruction vector table plus
// hand-written sequences for memory waits, reset, and counter wrap.
module tb_mips_mc_control;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;

    mips_mc_control_if bus ();

    mips_mc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cycles;
        int         retire;
        int         illegal;
        int         reg_w;
        int         reg_dst;
        int         m2r;
        int         pc_w;
        int         pc_w_cond;
        int         mem_req;
        int         mem_w;
        int         alu3;   // alu_ctl in the third cycle (-1: never reached)
        int         pcsrc3; // pc_src in the third cycle
    } vec_t;

    vec_t vecs[14];

    // Runs one instruction from FETCH (zero-wait memory) until FETCH returns.
    task automatic run_vec(input vec_t v);
        int cyc, n_ill, n_rw, n_rd, n_m2r, n_pcw, n_pcwc, n_req, n_mw, alu3, pc3;
        logic [31:0] r0;
        bus.opcode = v.op; bus.funct = v.fn; bus.zero = v.z; bus.mem_ready = 1'b1;
        #1;
        check({v.name, "/start_fetch"}, 32'(bus.state), 32'(S_FETCH));
        r0 = bus.retired;
        cyc = 0; n_ill = 0; n_rw = 0; n_rd = 0; n_m2r = 0; n_pcw = 0; n_pcwc = 0;
        n_req = 0; n_mw = 0; alu3 = -1; pc3 = -1;
        while (1) begin
            n_ill  += int'(bus.illegal);
            n_rw   += int'(bus.reg_w);
            n_rd   += int'(bus.reg_dst);
            n_m2r  += int'(bus.mem_to_reg);
            n_pcw  += int'(bus.pc_w);
            n_pcwc += int'(bus.pc_w_cond);
            n_req  += int'(bus.mem_req);
            n_mw   += int'(bus.mem_w);
            if (cyc == 2) begin
                alu3 = int'(bus.alu_ctl);
                pc3  = int'(bus.pc_src);
            end
            cyc++;
            @(negedge clk);
            if (bus.state == S_FETCH || cyc >= 20) break;
        end
        check({v.name, "/cycles"},    32'(cyc),    32'(v.cycles));
        check({v.name, "/retired"},   bus.retired - r0, 32'(v.retire));
        check({v.name, "/illegal"},   32'(n_ill),  32'(v.illegal));
        check({v.name, "/reg_w"},     32'(n_rw),   32'(v.reg_w));
        check({v.name, "/reg_dst"},   32'(n_rd),   32'(v.reg_dst));
        check({v.name, "/mem_to_reg"},32'(n_m2r),  32'(v.m2r));
        check({v.name, "/pc_w"},      32'(n_pcw),  32'(v.pc_w));
        check({v.name, "/pc_w_cond"}, 32'(n_pcwc), 32'(v.pc_w_cond));
        check({v.name, "/mem_req"},   32'(n_req),  32'(v.mem_req));
        check({v.name, "/mem_w"},     32'(n_mw),   32'(v.mem_w));
        check({v.name, "/alu_ctl3"},  32'(alu3),   32'(v.alu3));
        check({v.name, "/pc_src3"},   32'(pc3),    32'(v.pcsrc3));
    endtask

    state_e      lw_seq[7];
    int          waits;
    int          n_wb;
    logic [31:0] r_before;

    initial begin
        //             name     op     fn     z  cyc ret ill rw rd m2r pcw pcwc req mw alu3 pc3
        vecs[0]  = '{"lw",     6'h23, 6'h00, 0, 5,  1,  0,  1, 0, 1,  1,  0,   2,  0, 2,  0};
        vecs[1]  = '{"sw",     6'h2B, 6'h00, 0, 4,  1,  0,  0, 0, 0,  1,  0,   2,  1, 2,  0};
        vecs[2]  = '{"add",    6'h00, 6'h20, 0, 4,  1,  0,  1, 1, 0,  1,  0,   1,  0, 2,  0};
        vecs[3]  = '{"sub",    6'h00, 6'h22, 0, 4,  1,  0,  1, 1, 0,  1,  0,   1,  0, 6,  0};
        vecs[4]  = '{"and",    6'h00, 6'h24, 0, 4,  1,  0,  1, 1, 0,  1,  0,   1,  0, 0,  0};
        vecs[5]  = '{"or",     6'h00, 6'h25, 0, 4,  1,  0,  1, 1, 0,  1,  0,   1,  0, 1,  0};
        vecs[6]  = '{"slt",    6'h00, 6'h2A, 0, 4,  1,  0,  1, 1, 0,  1,  0,   1,  0, 7,  0};
        vecs[7]  = '{"addi",   6'h08, 6'h00, 0, 4,  1,  0,  1, 0, 0,  1,  0,   1,  0, 2,  0};
        vecs[8]  = '{"beq_z1", 6'h04, 6'h00, 1, 3,  1,  0,  0, 0, 0,  1,  1,   1,  0, 6,  1};
        vecs[9]  = '{"beq_z0", 6'h04, 6'h00, 0, 3,  1,  0,  0, 0, 0,  1,  1,   1,  0, 6,  1};
        vecs[10] = '{"j",      6'h02, 6'h00, 0, 3,  1,  0,  0, 0, 0,  2,  0,   1,  0, 0,  2};
        vecs[11] = '{"ill_3f", 6'h3F, 6'h00, 0, 2,  0,  1,  0, 0, 0,  1,  0,   1,  0, -1, -1};
        vecs[12] = '{"ill_fn", 6'h00, 6'h00, 0, 2,  0,  1,  0, 0, 0,  1,  0,   1,  0, -1, -1};
        vecs[13] = '{"ill_0d", 6'h0D, 6'h20, 0, 2,  0,  1,  0, 0, 0,  1,  0,   1,  0, -1, -1};

        // Reset held with mem_ready = 1: RST state, all strobes low, counter zero.
        rst = 1'b1; bus.mem_ready = 1'b1; bus.zero = 1'b0;
        bus.opcode = 6'h08; bus.funct = 6'h00;
        repeat (3) @(negedge clk);
        check("rst/state",   32'(bus.state),   32'(S_RST));
        check("rst/mem_req", 32'(bus.mem_req), 32'd0);
        check("rst/ir_w",    32'(bus.ir_w),    32'd0);
        check("rst/alu_ctl", 32'(bus.alu_ctl), 32'd0);
        check("rst/retired", bus.retired,      32'd0);
        rst = 1'b0;
        #1 check("rst/release_still_rst", 32'(bus.state), 32'(S_RST));
        @(negedge clk);
        check("rst/then_fetch", 32'(bus.state), 32'(S_FETCH));
        check("fetch/ir_w",     32'(bus.ir_w),  32'd1);
        check("fetch/pc_w",     32'(bus.pc_w),  32'd1);
        check("fetch/alu_src_b",32'(bus.alu_src_b), 32'(SRCB_FOUR));
        check("fetch/retired",  bus.retired,    32'd0);

        // Memory not ready in FETCH: request held, no IR/PC write, state held.
        bus.mem_ready = 1'b0;
        #1;
        check("fetch_wait/ir_w",    32'(bus.ir_w),    32'd0);
        check("fetch_wait/pc_w",    32'(bus.pc_w),    32'd0);
        check("fetch_wait/mem_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        check("fetch_wait/held", 32'(bus.state), 32'(S_FETCH));

        foreach (vecs[i]) run_vec(vecs[i]);

        // lw with two wait cycles in MEMRD.
        lw_seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};
        bus.opcode = 6'h23; bus.funct = 6'h00;
        waits = 2; n_wb = 0; r_before = bus.retired;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = !(bus.state == S_MEMRD && waits > 0);
            if (!bus.mem_ready) waits--;
            #1;
            check($sformatf("lw_wait/state%0d", i), 32'(bus.state), 32'(lw_seq[i]));
            n_wb += int'(bus.reg_w && bus.mem_to_reg);
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        check("lw_wait/back_fetch", 32'(bus.state), 32'(S_FETCH));
        check("lw_wait/wb_once",    32'(n_wb),      32'd1);
        check("lw_wait/retired",    bus.retired - r_before, 32'd1);

        // Counter wrap on a j retirement.
        bus.opcode = 6'h02; bus.funct = 6'h00;
        force dut.retired_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_q;
        @(negedge clk);
        check("wrap/in_jump",  32'(bus.state), 32'(S_JUMP));
        check("wrap/preload",  bus.retired,    32'hFFFF_FFFF);
        @(negedge clk);
        check("wrap/fetch",    32'(bus.state), 32'(S_FETCH));
        check("wrap/retired",  bus.retired,    32'd0);

        // Reset while sw waits in MEMWR: straight to RST, nothing retires.
        bus.opcode = 6'h2B;
        for (int i = 0; i < 10 && bus.state != S_MEMWR; i++) @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("rst_memwr/in_memwr", 32'(bus.state), 32'(S_MEMWR));
        check("rst_memwr/mem_w_on", 32'(bus.mem_w), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_memwr/state",   32'(bus.state), 32'(S_RST));
        check("rst_memwr/mem_w",   32'(bus.mem_w), 32'd0);
        check("rst_memwr/retired", bus.retired,    32'd0);
        rst = 1'b0; bus.mem_ready = 1'b1;
        @(negedge clk);
        check("rst_memwr/fetch", 32'(bus.state), 32'(S_FETCH));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
